// File: rtl/mc_arb_pkg.sv
// Shared definitions for the memory-controller Wishbone arbiter:
// FSM state encoding and default sizing constants.
package mc_arb_pkg;

    localparam int unsigned NUM_M_DEFAULT     = 4;
    localparam int unsigned TO_CYCLES_DEFAULT = 255;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_TOUT = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        BUSY = ST_BUSY,
        TOUT = ST_TOUT
    } arb_state_t;

endpackage

// File: rtl/mc_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping at NUM_M, returned as a one-hot grant plus a found flag.
module mc_rr_pick
    import mc_arb_pkg::*;
#(
    parameter int unsigned NUM_M = NUM_M_DEFAULT,
    parameter int unsigned PW    = $clog2(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [NUM_M-1:0] gnt,
    output logic             found
);

    logic [PW-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_M; i++) begin
            idx = PW'((32'(ptr) + i) % NUM_M);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mc_wb_arb.sv
// Round-robin Wishbone arbiter sharing one memory-controller slave port among
// NUM_M masters, with locked tenures and a stalled-bus timeout.
module mc_wb_arb
    import mc_arb_pkg::*;
#(
    parameter int unsigned NUM_M     = NUM_M_DEFAULT,
    parameter int unsigned TO_CYCLES = TO_CYCLES_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [NUM_M-1:0]    m_cyc_i,
    input  logic [NUM_M-1:0]    m_stb_i,
    input  logic [NUM_M-1:0]    m_we_i,
    input  logic [NUM_M*32-1:0] m_addr_i,
    input  logic [NUM_M*32-1:0] m_data_i,
    input  logic [NUM_M*4-1:0]  m_sel_i,
    output logic [31:0]         m_data_o,
    output logic [NUM_M-1:0]    m_ack_o,
    output logic [NUM_M-1:0]    m_err_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [31:0]         s_addr_o,
    output logic [31:0]         s_data_o,
    output logic [3:0]          s_sel_o,
    input  logic [31:0]         s_data_i,
    input  logic                s_ack_i,
    input  logic                s_err_i,
    output logic [NUM_M-1:0]    gnt_o,
    output logic                gnt_valid_o
);

    localparam int unsigned PW = $clog2(NUM_M);
    localparam int unsigned CW = $clog2(TO_CYCLES + 1);

    arb_state_t       state;
    logic [NUM_M-1:0] gnt_q;
    logic [PW-1:0]    ptr;
    logic [CW-1:0]    cnt;

    logic [NUM_M-1:0] pick_gnt;
    logic             pick_found;
    logic [PW-1:0]    gidx;
    logic [PW-1:0]    nxt_ptr;
    logic             cyc_g;
    logic             stall;
    logic             timeout;

    mc_rr_pick #(
        .NUM_M (NUM_M),
        .PW    (PW)
    ) u_pick (
        .req   (m_cyc_i),
        .ptr   (ptr),
        .gnt   (pick_gnt),
        .found (pick_found)
    );

    always_comb begin
        gidx = '0;
        for (int unsigned k = 0; k < NUM_M; k++) begin
            if (gnt_q[k]) gidx = PW'(k);
        end
    end

    assign nxt_ptr = (gidx == PW'(NUM_M - 1)) ? '0 : gidx + PW'(1);
    assign cyc_g   = |(gnt_q & m_cyc_i);

    // Slave-side mux: only the granted master is visible, and only in BUSY.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_data_o = '0;
        s_sel_o  = '0;
        if (state == BUSY) begin
            for (int unsigned k = 0; k < NUM_M; k++) begin
                if (gnt_q[k]) begin
                    s_cyc_o  = m_cyc_i[k];
                    s_stb_o  = m_stb_i[k];
                    s_we_o   = m_we_i[k];
                    s_addr_o = m_addr_i[32*k +: 32];
                    s_data_o = m_data_i[32*k +: 32];
                    s_sel_o  = m_sel_i[4*k +: 4];
                end
            end
        end
    end

    // A response on the limit cycle wins over the timeout because it clears stall.
    assign stall   = (state == BUSY) && s_cyc_o && s_stb_o && !s_ack_i && !s_err_i;
    assign timeout = stall && (cnt == CW'(TO_CYCLES - 1));

    assign m_ack_o     = (state == BUSY) ? (gnt_q & {NUM_M{s_ack_i}}) : '0;
    assign m_err_o     = (state == BUSY) ? (gnt_q & {NUM_M{s_err_i | timeout}}) : '0;
    assign m_data_o    = s_data_i;
    assign gnt_o       = gnt_q;
    assign gnt_valid_o = (state != IDLE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            gnt_q <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (pick_found) begin
                        gnt_q <= pick_gnt;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!cyc_g) begin
                        state <= IDLE;
                        gnt_q <= '0;
                        ptr   <= nxt_ptr;
                        cnt   <= '0;
                    end else if (timeout) begin
                        state <= TOUT;
                        cnt   <= '0;
                    end else if (stall) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        cnt <= '0;
                    end
                end
                TOUT: begin
                    cnt <= '0;
                    if (!cyc_g) begin
                        state <= IDLE;
                        gnt_q <= '0;
                        ptr   <= nxt_ptr;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt_q <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_wb_arb.sv
// Self-checking bench for mc_wb_arb: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a behavioural arbiter model.
module tb_mc_wb_arb;

    localparam int N  = 4;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   cyc, stb, we;
    logic [N*32-1:0] addr, wdata;
    logic [N*4-1:0] sel;
    logic [31:0]    rdata_o, s_addr, s_wdata, s_rdata;
    logic [N-1:0]   ack_o, err_o, gnt;
    logic           s_cyc, s_stb, s_we, s_ack, s_err, gvalid;
    logic [3:0]     s_sel;

    int total = 0;
    int bad   = 0;

    // Model state: owner index (-1 when nobody holds the bus), timeout flag,
    // round-robin start point and count of consecutive stalled beats.
    int m_owner, m_ptr, m_stall;
    bit m_tout;

    always #5 clk = ~clk;

    mc_wb_arb #(
        .NUM_M     (N),
        .TO_CYCLES (TO)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .m_cyc_i     (cyc),
        .m_stb_i     (stb),
        .m_we_i      (we),
        .m_addr_i    (addr),
        .m_data_i    (wdata),
        .m_sel_i     (sel),
        .m_data_o    (rdata_o),
        .m_ack_o     (ack_o),
        .m_err_o     (err_o),
        .s_cyc_o     (s_cyc),
        .s_stb_o     (s_stb),
        .s_we_o      (s_we),
        .s_addr_o    (s_addr),
        .s_data_o    (s_wdata),
        .s_sel_o     (s_sel),
        .s_data_i    (s_rdata),
        .s_ack_i     (s_ack),
        .s_err_i     (s_err),
        .gnt_o       (gnt),
        .gnt_valid_o (gvalid)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_stall = 0;
        m_tout  = 1'b0;
    endtask

    function automatic bit busy_now();
        return (m_owner >= 0) && !m_tout;
    endfunction

    function automatic bit fire_now();
        if (!busy_now()) return 1'b0;
        return cyc[m_owner] && stb[m_owner] && !s_ack && !s_err && (m_stall == TO - 1);
    endfunction

    task automatic check_all();
        logic [3:0]  e_ack, e_err, e_gnt, one;
        logic [6:0]  e_ctl;
        logic [31:0] e_addr, e_data;
        one    = 4'b0001;
        e_ack  = '0;
        e_err  = '0;
        e_gnt  = '0;
        e_ctl  = '0;
        e_addr = '0;
        e_data = '0;
        if (m_owner >= 0) e_gnt = one << m_owner;
        if (busy_now()) begin
            e_ctl  = {cyc[m_owner], stb[m_owner], we[m_owner], sel[4*m_owner +: 4]};
            e_addr = addr[32*m_owner +: 32];
            e_data = wdata[32*m_owner +: 32];
            if (s_ack) e_ack = one << m_owner;
            if (s_err || fire_now()) e_err = one << m_owner;
        end
        chk("s_ctrl", {s_cyc, s_stb, s_we, s_sel}, e_ctl);
        chk("s_addr", s_addr, e_addr);
        chk("s_wdata", s_wdata, e_data);
        chk("ack", ack_o, e_ack);
        chk("err", err_o, e_err);
        chk("gnt", {gvalid, gnt}, {m_owner >= 0, e_gnt});
        chk("rdata", rdata_o, s_rdata);
    endtask

    task automatic model_step();
        bit found;
        if (!rst_n) begin
            model_reset();
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!found && cyc[(m_ptr + i) % N]) begin
                    m_owner = (m_ptr + i) % N;
                    found   = 1'b1;
                end
            end
            m_stall = 0;
        end else if (!cyc[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_tout  = 1'b0;
            m_stall = 0;
        end else if (m_tout) begin
            m_stall = 0;
        end else if (fire_now()) begin
            m_tout  = 1'b1;
            m_stall = 0;
        end else if (stb[m_owner] && !s_ack && !s_err) begin
            m_stall++;
        end else begin
            m_stall = 0;
        end
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic tick();
        #1;
        check_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] drop_m;
        logic [N-1:0] gq[$];
        logic [N-1:0] exp_order[4];
        logic         pv;
        int           beats;

        rst_n = 1'b0;
        cyc = '0; stb = '0; we = '0; addr = '0; wdata = '0; sel = '0;
        s_rdata = 32'h1234_5678; s_ack = 1'b0; s_err = 1'b0;
        model_reset();
        @(negedge clk);
        tick();
        tick();
        rst_n = 1'b1;

        // Single master 2 write; one cycle arbitration latency.
        cyc = 4'b0100; stb = 4'b0100; we = 4'b0100;
        addr[64 +: 32] = 32'h0000_0010; wdata[64 +: 32] = 32'hA5A5_5A5A; sel[8 +: 4] = 4'hF;
        #1 chk("lat_idle_cyc", s_cyc, 1'b0);
        tick();
        #1 chk("lat_busy_bus", {s_cyc, s_stb, s_we, s_sel, s_addr, s_wdata},
                {3'b111, 4'hF, 32'h0000_0010, 32'hA5A5_5A5A});
        s_ack = 1'b1;
        #1 chk("ack_route", ack_o, 4'b0100);
        tick();
        s_ack = 1'b0; cyc = '0; stb = '0; we = '0;
        tick();
        tick();

        // Fair rotation among masters 0,1,3 from reset.
        rst_n = 1'b0; model_reset();
        tick();
        rst_n = 1'b1;
        drop_m = '0; pv = 1'b0;
        for (int c = 0; c < 40 && gq.size() < 4; c++) begin
            int ao;
            cyc = 4'b1011 & ~drop_m; stb = cyc;
            ao = m_owner;
            s_ack = busy_now() && cyc[m_owner];
            tick();
            drop_m = s_ack ? (4'b0001 << ao) : 4'b0000;
            if (gvalid && !pv) gq.push_back(gnt);
            pv = gvalid;
        end
        s_ack = 1'b0;
        exp_order = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
        chk("rr_count", gq.size(), 4);
        for (int i = 0; i < 4 && i < gq.size(); i++) chk("rr_order", gq[i], exp_order[i]);
        cyc = '0; stb = '0;
        tick();
        tick();

        // Locked 4-beat burst by master 1 while master 0 waits.
        cyc = 4'b0011; stb = 4'b0011; beats = 0;
        for (int c = 0; c < 20 && beats < 4; c++) begin
            s_ack = (m_owner == 1) && !m_tout;
            if (s_ack) begin
                #1 chk("burst_gnt", gnt, 4'b0010);
                beats++;
            end
            tick();
        end
        chk("burst_beats", beats, 4);
        s_ack = 1'b0; cyc = 4'b0001; stb = 4'b0001;
        tick();
        tick();
        #1 chk("after_burst_gnt", {gvalid, gnt}, {1'b1, 4'b0001});
        cyc = '0; stb = '0;
        tick();
        tick();

        // Timeout: slave never answers master 3.
        cyc = 4'b1000; stb = 4'b1000;
        tick();
        for (int i = 1; i <= TO; i++) begin
            #1 chk("tout_err", err_o, (i == TO) ? 4'b1000 : 4'b0000);
            tick();
        end
        #1 chk("tout_hold", {s_cyc, gvalid, err_o}, {1'b0, 1'b1, 4'b0000});
        tick();
        tick();
        cyc = '0; stb = '0;
        tick();
        #1 chk("tout_release", gvalid, 1'b0);

        // Ack landing exactly on the limit cycle suppresses the timeout.
        cyc = 4'b0100; stb = 4'b0100;
        tick();
        for (int i = 1; i < TO; i++) tick();
        s_ack = 1'b1;
        #1 chk("edge_ack", {ack_o, err_o}, {4'b0100, 4'b0000});
        tick();
        s_ack = 1'b0;
        #1 chk("edge_stay_busy", {gvalid, s_cyc}, 2'b11);
        cyc = '0; stb = '0;
        tick();
        tick();

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++) begin
                if (cyc[k]) cyc[k] = ($urandom_range(0, 9) != 0);
                else        cyc[k] = ($urandom_range(0, 3) == 0);
                stb[k] = cyc[k] && ($urandom_range(0, 4) != 0);
                we[k]  = $urandom_range(0, 1) == 1;
                addr[32*k +: 32]  = $urandom;
                wdata[32*k +: 32] = $urandom;
                sel[4*k +: 4]     = 4'($urandom_range(0, 15));
            end
            s_rdata = $urandom;
            s_ack   = ($urandom_range(0, 5) == 0);
            s_err   = ($urandom_range(0, 15) == 0);
            tick();
        end
        s_ack = 1'b0; s_err = 1'b0; cyc = '0; stb = '0;
        tick();
        tick();
        tick();

        // Asynchronous reset in the middle of a tenure.
        cyc = 4'b0010; stb = 4'b0010;
        tick();
        tick();
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk("async_rst_out", {s_cyc, s_stb, s_we, s_sel, s_addr, ack_o, err_o, gnt, gvalid}, '0);
        cyc = 4'b0011; stb = 4'b0011;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        #1 chk("post_rst_gnt", {gvalid, gnt}, {1'b1, 4'b0001});
        cyc = '0; stb = '0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_wb_arb.md
MC_WB_ARB -- requirements
Module: mc_wb_arb

Interface
REQ-001 Parameter NUM_M, default 4, number of Wishbone masters sharing the memory-controller slave port (2..8).
REQ-002 Parameter TO_CYCLES, default 255, bus-timeout limit in clk_i cycles (1..65535).
REQ-003 clk_i  input  1  single clock (the Wishbone clock); all state updates on rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 m_cyc_i / m_stb_i / m_we_i  input  NUM_M each  per-master cycle, strobe, write enable.
REQ-006 m_addr_i / m_data_i  input  NUM_M*32 each  per-master address and write data; master k occupies bits [32k+31:32k].
REQ-007 m_sel_i  input  NUM_M*4  per-master byte selects.
REQ-008 m_data_o  output  32  read data, broadcast to all masters.
REQ-009 m_ack_o / m_err_o  output  NUM_M each  per-master acknowledge and error.
REQ-010 s_cyc_o / s_stb_o / s_we_o  output  1 each  to the controller slave port.
REQ-011 s_addr_o / s_data_o  output  32 each; s_sel_o  output  4.
REQ-012 s_data_i  input  32; s_ack_i / s_err_i  input  1 each  from the controller.
REQ-013 gnt_o  output  NUM_M  one-hot registered grant; gnt_valid_o  output  1  grant active.

Function
REQ-014 FSM states: IDLE, BUSY, TOUT; reset state IDLE.
REQ-015 IDLE: when any m_cyc_i is high, register a one-hot grant for the first requester found searching upward (with wrap) from index ptr, then enter BUSY; no requests, stay IDLE.
REQ-016 Arbitration latency: exactly one cycle from m_cyc_i rising in IDLE to s_cyc_o high.
REQ-017 BUSY: s_cyc_o/s_stb_o/s_we_o/s_addr_o/s_data_o/s_sel_o combinationally equal to the granted master's inputs.
REQ-018 BUSY: m_ack_o[g]=s_ack_i and m_err_o[g]=s_err_i for granted g only; all other ack/err bits 0.
REQ-019 Grant SHALL NOT change while the granted master holds m_cyc_i high, regardless of other requests (locked bursts).
REQ-020 BUSY with granted m_cyc_i low: go to IDLE, ptr <= (g+1) mod NUM_M; s_cyc_o low that cycle; next tenure needs one IDLE cycle.
REQ-021 Timeout counter: width ceil(log2(TO_CYCLES+1)); increments each BUSY cycle with s_stb_o high and s_ack_i=s_err_i=0; clears on ack, err, s_stb_o low, or leaving BUSY.
REQ-022 Counter reaching TO_CYCLES: m_err_o[g] high for exactly that one cycle, next state TOUT.
REQ-023 Same cycle ack/err arrives and counter reaches TO_CYCLES: ack/err is forwarded, no timeout, counter clears.
REQ-024 TOUT: all s_* control outputs 0, m_ack_o/m_err_o 0; stay until m_cyc_i[g] low, then IDLE with ptr <= (g+1) mod NUM_M.
REQ-025 IDLE and TOUT: s_cyc_o=s_stb_o=s_we_o=0; s_addr_o, s_data_o, s_sel_o 0.
REQ-026 m_data_o = s_data_i at all times (unregistered).
REQ-027 gnt_valid_o high in BUSY and TOUT; gnt_o holds g there, 0 in IDLE.

Reset
REQ-028 rst_n_i low, at any time including mid-burst: state IDLE, ptr 0, counter 0, gnt_o 0, gnt_valid_o 0, all s_* outputs and m_ack_o/m_err_o 0 immediately.
REQ-029 First arbitration after reset release occurs on the first rising edge with rst_n_i high.

Structure
REQ-030 Shared package mc_arb_pkg holds the FSM state enum (IDLE, BUSY, TOUT) and default constants for NUM_M and TO_CYCLES.
REQ-031 One sub-module, mc_rr_pick: combinational round-robin picker (req vector, ptr -> one-hot grant, found flag).
REQ-032 Slave-side mux and ack/err routing live in mc_wb_arb; total RTL 120-400 lines.

Verification
REQ-033 Single master 2 requests write addr 0x0000_0010 data 0xA5A5_5A5A sel 0xF -> s_cyc_o high 1 cycle later, s_* match master 2, ack routed only to m_ack_o[2].
REQ-034 Masters 0,1,3 held requesting from reset, each releasing cyc after one ack -> grants in order 0,1,3,0, each tenure separated by one IDLE cycle.
REQ-035 Master 1 holds cyc for 4-beat burst while master 0 requests -> gnt_o stays 0010 for all 4 acks; master 0 granted only after master 1 drops cyc.
REQ-036 TO_CYCLES=8, slave never acks -> m_err_o[g] pulses once on 8th stalled cycle, s_cyc_o low next cycle, IDLE after master drops cyc.
REQ-037 s_ack_i arrives on exact timeout cycle -> ack forwarded, no err, stays BUSY.
REQ-038 rst_n_i asserted mid-burst between clock edges -> all outputs 0 asynchronously; after release, master 0 wins a simultaneous 0/1 request.
